// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register bank write port between the ALU and load
// writeback paths, and tracks pending writes per register for hazard stalls.
// Build option: define RF_ARB_RR_EN for round-robin arbitration; otherwise the
// load path has fixed priority over the ALU path.
module rf_wr_arbiter #(
    parameter int unsigned NREG = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_req_i,
    input  logic [4:0]      alu_dr_i,
    input  logic [31:0]     alu_data_i,
    output logic            alu_gnt_o,
    input  logic            mem_req_i,
    input  logic [4:0]      mem_dr_i,
    input  logic [31:0]     mem_data_i,
    output logic            mem_gnt_o,
    input  logic            iss_valid_i,
    input  logic [4:0]      iss_dr_i,
    input  logic            chk_valid_i,
    input  logic [4:0]      chk_sr1_i,
    input  logic [4:0]      chk_sr2_i,
    output logic            stall_o,
    output logic [NREG-1:0] busy_o,
    output logic            rf_write_o,
    output logic [4:0]      rf_dr_o,
    output logic [31:0]     rf_wr_data_o
);

    localparam int unsigned IdxW = (NREG > 1) ? $clog2(NREG) : 1;

    function automatic logic in_range(input logic [4:0] r);
        return 32'(r) < NREG;
    endfunction

    logic            alu_gnt, mem_gnt;
    logic [4:0]      sel_dr;
    logic [31:0]     sel_data;
    logic            accept;

    logic            rf_write_q, rf_write_d;
    logic [4:0]      rf_dr_q, rf_dr_d;
    logic [31:0]     rf_data_q, rf_data_d;
    logic [NREG-1:0] busy_q, busy_d;

`ifdef RF_ARB_RR_EN
    // 1: the load path wins the next conflict (ALU was granted most recently)
    logic rr_mem_q, rr_mem_d;

    // Grant decode; grants are suppressed while reset is asserted
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (rst_ni) begin
            if (alu_req_i && mem_req_i) begin
                if (rr_mem_q) mem_gnt = 1'b1;
                else          alu_gnt = 1'b1;
            end else begin
                alu_gnt = alu_req_i;
                mem_gnt = mem_req_i;
            end
        end
    end

    // Pointer moves only on a granted cycle, away from the requester just served
    always_comb begin
        rr_mem_d = rr_mem_q;
        if (alu_gnt)      rr_mem_d = 1'b1;
        else if (mem_gnt) rr_mem_d = 1'b0;
    end

    // Round-robin pointer state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_mem_q <= 1'b0;
        else         rr_mem_q <= rr_mem_d;
    end
`else
    // Fixed priority: the load path always wins
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (rst_ni) begin
            mem_gnt = mem_req_i;
            alu_gnt = alu_req_i & ~mem_req_i;
        end
    end
`endif

    // Select the granted payload; out-of-range destinations are granted but dropped
    always_comb begin
        sel_dr     = mem_gnt ? mem_dr_i   : alu_dr_i;
        sel_data   = mem_gnt ? mem_data_i : alu_data_i;
        accept     = (alu_gnt | mem_gnt) & in_range(sel_dr);
        rf_write_d = accept;
        rf_dr_d    = accept ? sel_dr   : rf_dr_q;
        rf_data_d  = accept ? sel_data : rf_data_q;
    end

    // Scoreboard next state: clear on the bank write, then set on issue (set wins)
    always_comb begin
        busy_d = busy_q;
        if (rf_write_q) busy_d[rf_dr_q[IdxW-1:0]] = 1'b0;
        if (iss_valid_i && in_range(iss_dr_i) && (iss_dr_i != 5'd0)) begin
            busy_d[iss_dr_i[IdxW-1:0]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Registered bank write port and scoreboard
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_write_q <= 1'b0;
            rf_dr_q    <= 5'd0;
            rf_data_q  <= 32'd0;
            busy_q     <= '0;
        end else begin
            rf_write_q <= rf_write_d;
            rf_dr_q    <= rf_dr_d;
            rf_data_q  <= rf_data_d;
            busy_q     <= busy_d;
        end
    end

    // Hazard detect; out-of-range sources never stall
    always_comb begin
        stall_o = chk_valid_i &
                  ((in_range(chk_sr1_i) & busy_q[chk_sr1_i[IdxW-1:0]]) |
                   (in_range(chk_sr2_i) & busy_q[chk_sr2_i[IdxW-1:0]]));
    end

    assign alu_gnt_o    = alu_gnt;
    assign mem_gnt_o    = mem_gnt;
    assign busy_o       = busy_q;
    assign rf_write_o   = rf_write_q;
    assign rf_dr_o      = rf_dr_q;
    assign rf_wr_data_o = rf_data_q;

endmodule
